// File: rtl/pass_scheduler.sv
// Layer-level sequencer: walks oc (outer) / row (middle) / ic (inner) tiles for one layer,
// issuing one pass_start per pass and advancing on each pass_done.
module pass_scheduler #(
  parameter int CW = 16,
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          layer_start_i,
  input  logic [1:0]    layer_type_i,
  input  logic [CW-1:0] oc_tiles_i,
  input  logic [CW-1:0] ic_tiles_i,
  input  logic [RW-1:0] out_rows_i,
  input  logic [RW-1:0] tile_rows_i,
  input  logic          pass_done_i,
  output logic          pass_start_o,
  output logic [RW-1:0] On_real_o,
  output logic [CW-1:0] oc_idx_o,
  output logic [RW-1:0] row_base_o,
  output logic [CW-1:0] ic_idx_o,
  output logic          first_ic_o,
  output logic          last_ic_o,
  output logic          busy_o,
  output logic          layer_done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_e;

  localparam logic [1:0] LT_DEPTHWISE = 2'd1;

  state_e        state_q, state_d;
  logic [CW-1:0] oc_tiles_q, oc_tiles_d;
  logic [CW-1:0] ic_eff_q, ic_eff_d;
  logic [RW-1:0] out_rows_q, out_rows_d;
  logic [RW-1:0] tile_rows_q, tile_rows_d;
  logic [CW-1:0] oc_idx_q, oc_idx_d;
  logic [CW-1:0] ic_idx_q, ic_idx_d;
  logic [RW-1:0] row_base_q, row_base_d;

  logic [CW-1:0] ic_eff_in;
  logic [RW:0]   row_end;
  logic          row_last;
  logic          ic_last;
  logic          oc_last;
  logic [RW-1:0] rows_left;
  logic          in_pass;

  // Depthwise layers have no input-channel reduction, so exactly one ic tile.
  assign ic_eff_in = (layer_type_i == LT_DEPTHWISE) ? CW'(1) : ic_tiles_i;

  // Extra bit keeps the last-row test correct when row_base + tile_rows wraps RW bits.
  assign row_end   = {1'b0, row_base_q} + {1'b0, tile_rows_q};
  assign row_last  = (row_end >= {1'b0, out_rows_q});
  assign ic_last   = (ic_idx_q == ic_eff_q - CW'(1));
  assign oc_last   = (oc_idx_q == oc_tiles_q - CW'(1));
  assign rows_left = out_rows_q - row_base_q;
  assign in_pass   = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_ADVANCE);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    oc_tiles_d  = oc_tiles_q;
    ic_eff_d    = ic_eff_q;
    out_rows_d  = out_rows_q;
    tile_rows_d = tile_rows_q;
    oc_idx_d    = oc_idx_q;
    ic_idx_d    = ic_idx_q;
    row_base_d  = row_base_q;

    unique case (state_q)
      S_IDLE: begin
        if (layer_start_i) begin
          oc_tiles_d  = oc_tiles_i;
          ic_eff_d    = ic_eff_in;
          out_rows_d  = out_rows_i;
          tile_rows_d = tile_rows_i;
          oc_idx_d    = '0;
          ic_idx_d    = '0;
          row_base_d  = '0;
          if ((oc_tiles_i == '0) || (ic_eff_in == '0) ||
              (out_rows_i == '0) || (tile_rows_i == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (pass_done_i) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        state_d = S_ISSUE;
        if (!ic_last) begin
          ic_idx_d = ic_idx_q + CW'(1);
        end else if (!row_last) begin
          ic_idx_d   = '0;
          row_base_d = row_base_q + tile_rows_q;
        end else if (!oc_last) begin
          ic_idx_d   = '0;
          row_base_d = '0;
          oc_idx_d   = oc_idx_q + CW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the latched config is a handful of flops, not a memory, so it is reset along with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      oc_tiles_q  <= '0;
      ic_eff_q    <= '0;
      out_rows_q  <= '0;
      tile_rows_q <= '0;
      oc_idx_q    <= '0;
      ic_idx_q    <= '0;
      row_base_q  <= '0;
    end else begin
      state_q     <= state_d;
      oc_tiles_q  <= oc_tiles_d;
      ic_eff_q    <= ic_eff_d;
      out_rows_q  <= out_rows_d;
      tile_rows_q <= tile_rows_d;
      oc_idx_q    <= oc_idx_d;
      ic_idx_q    <= ic_idx_d;
      row_base_q  <= row_base_d;
    end
  end

  always_comb begin
    pass_start_o = (state_q == S_ISSUE);
    layer_done_o = (state_q == S_DONE);
    busy_o       = (state_q != S_IDLE);
    oc_idx_o     = oc_idx_q;
    ic_idx_o     = ic_idx_q;
    row_base_o   = row_base_q;
    first_ic_o   = in_pass && (ic_idx_q == '0);
    last_ic_o    = in_pass && ic_last;
    On_real_o    = '0;
    if (state_q != S_IDLE) begin
      On_real_o = (tile_rows_q < rows_left) ? tile_rows_q : rows_left;
    end
  end

endmodule

// File: tb/tb_pass_scheduler.sv
// Scoreboard bench for pass_scheduler: a loop-nest model queues the expected pass
// descriptors per layer; each observed pass_start pops one and compares it.
module tb_pass_scheduler;

  localparam int CW = 16;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          layer_start_i = 1'b0;
  logic [1:0]    layer_type_i = '0;
  logic [CW-1:0] oc_tiles_i = '0;
  logic [CW-1:0] ic_tiles_i = '0;
  logic [RW-1:0] out_rows_i = '0;
  logic [RW-1:0] tile_rows_i = '0;
  logic          pass_done_i = 1'b0;
  logic          pass_start_o;
  logic [RW-1:0] On_real_o;
  logic [CW-1:0] oc_idx_o;
  logic [RW-1:0] row_base_o;
  logic [CW-1:0] ic_idx_o;
  logic          first_ic_o;
  logic          last_ic_o;
  logic          busy_o;
  logic          layer_done_o;

  pass_scheduler #(.CW(CW), .RW(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .layer_start_i(layer_start_i),
    .layer_type_i (layer_type_i),
    .oc_tiles_i   (oc_tiles_i),
    .ic_tiles_i   (ic_tiles_i),
    .out_rows_i   (out_rows_i),
    .tile_rows_i  (tile_rows_i),
    .pass_done_i  (pass_done_i),
    .pass_start_o (pass_start_o),
    .On_real_o    (On_real_o),
    .oc_idx_o     (oc_idx_o),
    .row_base_o   (row_base_o),
    .ic_idx_o     (ic_idx_o),
    .first_ic_o   (first_ic_o),
    .last_ic_o    (last_ic_o),
    .busy_o       (busy_o),
    .layer_done_o (layer_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] oc;
    logic [RW-1:0] rb;
    logic [CW-1:0] ic;
    logic [RW-1:0] onr;
    logic          first;
    logic          last;
  } pass_t;

  pass_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference loop nest, written independently of the hardware's increment/compare scheme.
  task automatic push_model(input int ty, input int oc, input int ic, input int rows, input int tr);
    int    ic_eff;
    pass_t p;
    ic_eff = (ty == 1) ? 1 : ic;
    if (oc == 0 || ic_eff == 0 || rows == 0 || tr == 0) return;
    for (int o = 0; o < oc; o++) begin
      for (int rb = 0; rb < rows; rb += tr) begin
        for (int i = 0; i < ic_eff; i++) begin
          p.oc    = CW'(o);
          p.rb    = RW'(rb);
          p.ic    = CW'(i);
          p.onr   = RW'((rows - rb < tr) ? rows - rb : tr);
          p.first = (i == 0);
          p.last  = (i == ic_eff - 1);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pass_start"}, 64'(pass_start_o), 0);
    check({tag, "_busy"},       64'(busy_o), 0);
    check({tag, "_layer_done"}, 64'(layer_done_o), 0);
    check({tag, "_on_real"},    64'(On_real_o), 0);
    check({tag, "_idx"},        64'({oc_idx_o, ic_idx_o}), 0);
    check({tag, "_row_base"},   64'(row_base_o), 0);
    check({tag, "_flags"},      64'({first_ic_o, last_ic_o}), 0);
  endtask

  // All driving and sampling happens at negedge; the DUT acts on the following posedge.
  task automatic run_layer(input int ty, input int oc, input int ic, input int rows, input int tr,
                           input int abort_at, input bit spurious);
    pass_t e;
    int    n = 0;
    int    n_exp;
    push_model(ty, oc, ic, rows, tr);
    n_exp = exp_q.size();
    @(negedge clk);
    layer_type_i  = 2'(ty);
    oc_tiles_i    = CW'(oc);
    ic_tiles_i    = CW'(ic);
    out_rows_i    = RW'(rows);
    tile_rows_i   = RW'(tr);
    layer_start_i = 1'b1;
    pass_done_i   = spurious;  // coincident done in IDLE must be ignored
    @(negedge clk);
    layer_start_i = 1'b0;
    pass_done_i   = 1'b0;
    check("busy_after_start", 64'(busy_o), 1);
    if (n_exp == 0) begin
      check("zero_layer_done", 64'(layer_done_o), 1);
      check("zero_no_pass",    64'(pass_start_o), 0);
      @(negedge clk);
      check("zero_busy_drop",  64'(busy_o), 0);
      check("zero_done_pulse", 64'(layer_done_o), 0);
      return;
    end
    while (exp_q.size() > 0) begin
      check("pass_start_timing", 64'(pass_start_o), 1);
      e = exp_q.pop_front();
      n++;
      check("oc_idx",   64'(oc_idx_o),   64'(e.oc));
      check("row_base", 64'(row_base_o), 64'(e.rb));
      check("ic_idx",   64'(ic_idx_o),   64'(e.ic));
      check("on_real",  64'(On_real_o),  64'(e.onr));
      check("first_ic", 64'(first_ic_o), 64'(e.first));
      check("last_ic",  64'(last_ic_o),  64'(e.last));
      if (spurious) pass_done_i = 1'b1;
      @(negedge clk);
      pass_done_i = 1'b0;
      check("start_width", 64'(pass_start_o), 0);
      check("wait_stable", 64'({oc_idx_o, ic_idx_o}), 64'({e.oc, e.ic}));
      if (spurious && n == 2) begin
        layer_start_i = 1'b1;
        oc_tiles_i    = CW'(9);
        tile_rows_i   = RW'(1);
        @(negedge clk);
        layer_start_i = 1'b0;
        check("restart_ignored_busy", 64'(busy_o), 1);
      end else begin
        @(negedge clk);
      end
      if (abort_at == n) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("abort_no_pass", 64'(pass_start_o), 0);
        end
        return;
      end
      pass_done_i = 1'b1;
      @(negedge clk);
      pass_done_i = 1'b0;
      @(negedge clk);
    end
    check("pass_count",     64'(n), 64'(n_exp));
    check("layer_done",     64'(layer_done_o), 1);
    check("no_extra_start", 64'(pass_start_o), 0);
    @(negedge clk);
    check("busy_drop",       64'(busy_o), 0);
    check("done_pulse_once", 64'(layer_done_o), 0);
    check("idle_on_real",    64'(On_real_o), 0);
    check("idle_flags",      64'({first_ic_o, last_ic_o}), 0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_layer(2, 2, 3, 10, 4, 0, 1'b0);  // STANDARD, 18 passes
    run_layer(1, 3, 5, 8, 8, 0, 1'b0);   // DEPTHWISE, 3 passes
    run_layer(0, 1, 1, 1, 1, 0, 1'b0);   // POINTWISE, 1 pass
    run_layer(2, 2, 0, 10, 4, 0, 1'b0);  // zero ic_tiles
    run_layer(3, 1, 2, 7, 3, 0, 1'b1);   // LINEAR with spurious done/start
    run_layer(2, 2, 3, 10, 4, 5, 1'b0);  // reset during WAIT of pass 5
    run_layer(2, 1, 2, 5, 4, 0, 1'b0);   // restart from (0,0,0) after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
